da_dct_sequencer: RTL and testbench
===================================

// Module: da_dct_sequencer
// PURPOSE
// - Sequences the bank of eight distributed-arithmetic (DA) coefficient ROMs (Z1..Z8) for the 8-point DCT.
// - Accepts one 8-sample block; forms butterfly sums/differences; walks them bit-serially LSB-first.
// - Builds and folds each ROM address, sign-corrects the ROM data, shift-accumulates, returns 8 coefficients.
// - Sits between the sample framer and the RLE stage.
// PARAMETERS
// - SAMPLE_W  16  signed input sample width.
// - B         17  butterfly operand width (SAMPLE_W+1); also the RUN length in cycles.
// - ROM_W     16  ROM word width, signed Q2.14.
// - ROM_FRAC  14  fractional bits of the ROM word.
// - ACC_W     34  accumulator width (ROM_W+B+1).
// - OUT_W     20  signed output coefficient width.
// PORTS
// - clk        in   1          rising-edge clock.
// - rst        in   1          synchronous, active-high reset.
// - in_valid   in   1          block on in_x is valid.
// - in_ready   out  1          sequencer can accept a block.
// - in_x       in   8*SAMPLE_W x0..x7 packed, x0 in LSBs, signed.
// - rom_cs     out  8          chip select, one per ROM; ROM outputs 0 when low.
// - rom_addr   out  8*3        folded 3-bit address per ROM, ROM k in bits [3k+2:3k].
// - rom_data   in   8*ROM_W    combinational ROM read data, ROM k in bits [16k+15:16k].
// - out_valid  out  1          coefficients on out_z are valid.
// - out_ready  in   1          downstream accepts out_z.
// - out_z      out  8*OUT_W    z0..z7 packed, z0 in LSBs, signed.
// BEHAVIOUR
// - Reset values: in_ready=0 during rst, then 1; out_valid=0; rom_cs=0; rom_addr=0; out_z=0; accumulators=0; bit counter=0.
// - States and transitions:
//   - IDLE: in_ready=1; in_valid&in_ready goes to LOAD.
//   - LOAD (1 cycle): a_i=x_i+x_(7-i) and d_i=x_i-x_(7-i) for i=0..3, B-bit signed, into shift registers; accs cleared.
//   - RUN (B cycles, j=0..B-1).
//   - DONE: out_valid=1; out_valid&out_ready goes to IDLE.
// - in_ready=1 only in IDLE. A block presented in any other state is not taken.
// - Nibble per ROM and cycle:
//   - even ROMs (z0,z2,z4,z6): nib={a0[j],a1[j],a2[j],a3[j]}, a0 is the MSB.
//   - odd ROMs (z1,z3,z5,z7): the same with d_i.
// - Fold: nib[3]=0 gives addr=nib[2:0], t=+rom_data. nib[3]=1 gives addr=~nib[2:0], t=-rom_data (sign-extended, 2's complement).
// - Accumulate:
//   - j<B-1: acc += t<<<j.
//   - j=B-1 (operand sign bit): acc -= t<<<j.
// - rom_cs=8'hFF only in RUN. rom_addr is combinational from the current shift-register slice.
// - Leaving RUN: out_z[k] = sat_OUT_W(acc[k]>>>ROM_FRAC), arithmetic shift, truncating, saturating to +/-(2^(OUT_W-1)-1 / 2^(OUT_W-1)).
// - out_z is registered and held stable while out_valid=1 and out_ready=0.
// - Latency: handshake in cycle 0; LOAD cycle 1; RUN cycles 2..B+1; out_valid first high in cycle B+2 (19 at default).
// - Throughput: one block per B+3 cycles when out_ready is held high.
// - rst mid-operation (any state): return to IDLE next edge. Abandoned block is discarded; no partial out_valid.
// - out_ready with out_valid=0 is ignored. in_valid is ignored outside IDLE.
// STRUCTURE
// - Shared package dct_pkg: SAMPLE_W, B, ROM_W, ROM_FRAC, ACC_W, OUT_W; state_t enum {IDLE,LOAD,RUN,DONE}; sat_out() function.
// - One sub-module da_acc_lane, instantiated x8: nib -> fold -> sign-correct -> shift-accumulate -> saturate.
// - The ROM bank lives outside this block and is wired by the parent.
// TESTING
// - Golden model: float DCT with 0.5*c_k scaling using the standard ROM set; tolerance +/-1 LSB.
// - All-zero block -> out_z all 0; out_valid in cycle 19; rom_addr=0 throughout RUN.
// - x0..x7=100 -> z0=283+/-1; z1..z7=0+/-1; odd-ROM nibbles all 0 every RUN cycle.
// - Fold check: a0..a3 bits at j=0 give nib=1010 -> rom_addr=3'b101 and lane term = -rom_data; nib=0101 -> addr 101, term +rom_data.
// - Extremes: x0..x3=32767, x4..x7=-32768 -> d_i=65535 with no wrap; matches model within +/-1 or saturates exactly to the OUT_W limit.
// - Backpressure: out_ready=0 for 10 cycles after out_valid -> out_z stable, in_ready=0, second in_valid ignored until handshake.
// - Reset mid-RUN at j=8 -> next cycle IDLE, out_valid=0, rom_cs=0; next block's result is bit-exact to a clean run.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared widths, FSM states and output saturation for the DA DCT sequencer.
// The sequencer and its accumulator lanes import this package.
package dct_pkg;

  localparam int SAMPLE_W = 16;
  localparam int B        = 17;
  localparam int ROM_W    = 16;
  localparam int ROM_FRAC = 14;
  localparam int ACC_W    = 34;
  localparam int OUT_W    = 20;
  localparam int JW       = 5;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    (ACC_W'(1) <<< (OUT_W-1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  function automatic logic [B-1:0] sx(
    input logic [SAMPLE_W-1:0] v
  );
    return {v[SAMPLE_W-1], v};
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] s;
    s = v >>> ROM_FRAC;
    if (s > SAT_HI)
      return SAT_HI[OUT_W-1:0];
    else if (s < SAT_LO)
      return SAT_LO[OUT_W-1:0];
    else
      return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/da_acc_lane.sv
// One DA lane: fold nibble to ROM address, sign-correct the ROM word,
// shift-accumulate it and present the saturated coefficient.
module da_acc_lane
  import dct_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             last,
  input  logic [JW-1:0]    j,
  input  logic [3:0]       nib,
  input  logic [ROM_W-1:0] rom_data,
  output logic [2:0]       rom_addr,
  output logic [OUT_W-1:0] z
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] t;
  logic signed [ACC_W-1:0] sh;

  // ROM holds only the lower half; the upper half is its negation
  assign rom_addr = nib[3] ? ~nib[2:0] : nib[2:0];

  assign t = nib[3] ? -ACC_W'($signed(rom_data))
                    :  ACC_W'($signed(rom_data));

  assign sh = t <<< j;

  always_comb begin
    acc_nxt = acc;
    if (en)
      acc_nxt = last ? acc - sh : acc + sh;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else
      acc <= acc_nxt;
  end

  assign z = sat_out(acc_nxt);

endmodule

// File: rtl/da_dct_sequencer.sv
// 8-point DA DCT sequencer: butterflies a block, walks it bit-serially
// through the external ROM bank and returns eight coefficients.
module da_dct_sequencer
  import dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*SAMPLE_W-1:0] in_x,
  output logic [7:0]            rom_cs,
  output logic [8*3-1:0]        rom_addr,
  input  logic [8*ROM_W-1:0]    rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*OUT_W-1:0]    out_z
);

  state_t state;
  state_t state_nxt;

  logic [B-1:0]     a_sr [4];
  logic [B-1:0]     d_sr [4];
  logic [JW-1:0]    j;
  logic             last;
  logic             accept;
  logic [3:0]       nib_a;
  logic [3:0]       nib_d;
  logic [OUT_W-1:0] z [8];

  assign accept = in_valid && in_ready;
  assign last   = (j == JW'(B-1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign rom_cs    = (state == RUN) ? 8'hFF : 8'h00;

  // Zero-fill shifts leave the registers clear once a run completes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        a_sr[i] <= '0;
        d_sr[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        a_sr[i] <= sx(in_x[i*SAMPLE_W +: SAMPLE_W])
                 + sx(in_x[(7-i)*SAMPLE_W +: SAMPLE_W]);
        d_sr[i] <= sx(in_x[i*SAMPLE_W +: SAMPLE_W])
                 - sx(in_x[(7-i)*SAMPLE_W +: SAMPLE_W]);
      end
    end else if (state == RUN) begin
      for (int i = 0; i < 4; i++) begin
        a_sr[i] <= a_sr[i] >> 1;
        d_sr[i] <= d_sr[i] >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == LOAD)
      j <= '0;
    else if (state == RUN)
      j <= j + JW'(1);
  end

  assign nib_a = {a_sr[0][0], a_sr[1][0], a_sr[2][0], a_sr[3][0]};
  assign nib_d = {d_sr[0][0], d_sr[1][0], d_sr[2][0], d_sr[3][0]};

  for (genvar k = 0; k < 8; k++) begin : g_lane
    da_acc_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == LOAD),
      .en       (state == RUN),
      .last     (last),
      .j        (j),
      .nib      ((k % 2 == 1) ? nib_d : nib_a),
      .rom_data (rom_data[k*ROM_W +: ROM_W]),
      .rom_addr (rom_addr[k*3 +: 3]),
      .z        (z[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_z <= '0;
    else if (state == RUN && last)
      for (int k = 0; k < 8; k++)
        out_z[k*OUT_W +: OUT_W] <= z[k];
  end

endmodule

// File: tb/tb_da_dct_sequencer.sv
// Scoreboard bench for da_dct_sequencer with an offset-binary DA ROM model
// and an algebraic (non bit-serial) reference for the coefficients.
module tb_da_dct_sequencer;
  import dct_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_x;
  logic [7:0]   rom_cs;
  logic [23:0]  rom_addr;
  logic [127:0] rom_data;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_z;

  always #5 clk = ~clk;

  da_dct_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z)
  );

  int           n_checks = 0;
  int           n_err    = 0;
  longint       q [8][4];
  logic [15:0]  rom_tab [8][8];
  logic [159:0] exp_q [$];
  logic [159:0] last_z = '0;
  logic [159:0] e_m;

  always_comb begin
    rom_data = '0;
    for (int k = 0; k < 8; k++)
      if (rom_cs[k])
        rom_data[k*16 +: 16] = rom_tab[k][rom_addr[k*3 +: 3]];
  end

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_roms();
    real c, v;
    longint s;
    for (int k = 0; k < 8; k++) begin
      c = (k == 0) ? 0.5 * 0.7071067811865476 : 0.5;
      for (int i = 0; i < 4; i++) begin
        v = c * $cos((2*i+1) * k * 3.141592653589793 / 16.0) * 8192.0;
        q[k][i] = 2 * longint'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
      end
      for (int a = 0; a < 8; a++) begin
        s = -q[k][0];
        for (int i = 1; i < 4; i++)
          s += ((a >> (3-i)) & 1) != 0 ? q[k][i] : -q[k][i];
        rom_tab[k][a] = 16'(s / 2);
      end
    end
  endtask

  function automatic logic [159:0] model(input logic [127:0] x);
    logic [159:0] r;
    longint xs [8];
    longint acc, v, zz;
    r = '0;
    for (int n = 0; n < 8; n++)
      xs[n] = longint'($signed(x[n*16 +: 16]));
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        v = (k % 2 == 0) ? xs[i] + xs[7-i] : xs[i] - xs[7-i];
        acc += q[k][i] * v + q[k][i] / 2;
      end
      zz = acc >>> 14;
      if (zz > 524287) zz = 524287;
      if (zz < -524288) zz = -524288;
      r[k*20 +: 20] = 20'(zz);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e_m = exp_q.pop_front();
        for (int k = 0; k < 8; k++)
          chk($sformatf("z%0d", k), $signed(out_z[k*20 +: 20]),
              $signed(e_m[k*20 +: 20]));
      end
      last_z = out_z;
    end
  end

  task automatic hs(input logic [127:0] x, input bit push);
    int t;
    @(posedge clk); #1;
    in_x = x;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) chk("hs_timeout", 0, 1);
    else if (push) exp_q.push_back(model(x));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic [23:0] fa,
                          output logic [23:0] ao, output int runs);
    lat = 0; fa = '0; ao = '0; runs = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (rom_cs == 8'hFF) begin
        if (runs == 0) fa = rom_addr;
        ao |= rom_addr;
        runs++;
      end
    end
  endtask

  function automatic logic [127:0] blk(input int v0, input int v1);
    logic [127:0] x;
    for (int n = 0; n < 8; n++)
      x[n*16 +: 16] = 16'(n < 4 ? v0 : v1);
    return x;
  endfunction

  function automatic bit near(input logic [159:0] z, input int k,
                              input longint val);
    longint d;
    d = longint'($signed(z[k*20 +: 20])) - val;
    return (d >= -1 && d <= 1);
  endfunction

  initial begin
    int lat, runs, t, vcount;
    logic [23:0] fa, ao;
    logic [127:0] x, xc;
    logic [159:0] hold;
    bit stable, irdy, ok;

    build_roms();
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_z", out_z == '0, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    hs('0, 1);
    wait_out(lat, fa, ao, runs);
    chk("zero_latency", lat, 19);
    chk("zero_run_cycles", runs, 17);
    chk("zero_addr", ao, 0);
    @(posedge clk); #1;
    ok = 1;
    for (int k = 0; k < 8; k++) if (!near(last_z, k, 0)) ok = 0;
    chk("zero_tol", ok, 1);

    hs(blk(100, 100), 1);
    wait_out(lat, fa, ao, runs);
    chk("dc_latency", lat, 19);
    chk("dc_odd_addr", ao & 24'hE38E38, 0);
    @(posedge clk); #1;
    chk("dc_z0_283", near(last_z, 0, 283), 1);
    ok = 1;
    for (int k = 1; k < 8; k++) if (!near(last_z, k, 0)) ok = 0;
    chk("dc_zk_zero", ok, 1);

    x = '0; x[15:0] = 16'd1; x[47:32] = 16'd1;
    hs(x, 1);
    wait_out(lat, fa, ao, runs);
    chk("fold_1010_even", fa[2:0], 3'b101);
    chk("fold_1010_odd", fa[5:3], 3'b101);
    x = '0; x[31:16] = 16'd1; x[63:48] = 16'd1;
    hs(x, 1);
    wait_out(lat, fa, ao, runs);
    chk("fold_0101_even", fa[2:0], 3'b101);

    hs(blk(32767, -32768), 1);
    wait_out(lat, fa, ao, runs);
    hs(blk(32767, 32767), 1);
    wait_out(lat, fa, ao, runs);
    hs(blk(-32768, 32767), 1);
    wait_out(lat, fa, ao, runs);
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) x[n*32 +: 32] = $urandom;
      hs(x, 1);
      wait_out(lat, fa, ao, runs);
      chk("rand_latency", lat, 19);
    end

    @(posedge clk); #1 out_ready = 1'b0;
    x = blk(1234, -777);
    xc = blk(-5000, 20000);
    hs(x, 1);
    wait_out(lat, fa, ao, runs);
    chk("bp_latency", lat, 19);
    hold = out_z; stable = 1; irdy = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin in_x = xc; in_valid = 1'b1; end
      @(negedge clk);
      if (out_z !== hold || !out_valid) stable = 0;
      if (in_ready) irdy = 1;
    end
    chk("bp_out_z_stable", stable, 1);
    chk("bp_in_ready_low", irdy, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(in_ready && in_valid) && t < 50);
    chk("bp_second_hs", in_ready, 1);
    if (in_ready) exp_q.push_back(model(xc));
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat, fa, ao, runs);
    chk("bp2_latency", lat, 19);

    x = blk(-31000, 15000);
    hs(x, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rom_cs", rom_cs, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_idle", in_ready, 1);
    vcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("midrst_no_output", vcount, 0);
    hs(x, 1);
    wait_out(lat, fa, ao, runs);
    chk("post_rst_latency", lat, 19);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
